seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised Mealy serial-pattern detector; generalises the fixed 11011 non-overlapping detector.
- Pattern, its length (1..MAX_W) and overlap mode are runtime-programmable.
- Input is qualified by a valid strobe; a saturating match counter is provided.
- Sits on a serial bit stream after a deserialiser or sampler, feeding event/interrupt logic.

Parameters:
- MAX_W, 8: maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_W+1): width of cfg_len.
- CNT_W, 8: width of match_cnt.
- DEF_PATTERN, 8'b0001_1011: reset pattern, LSB-aligned.
- DEF_LEN, 5: reset pattern length.
- DEF_OVERLAP, 0: reset overlap mode.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies in this cycle.
- in  in  1  serial data bit.
- cfg_load  in  1  single-cycle pulse: load cfg_* fields.
- cfg_pattern  in  MAX_W  pattern, LSB-aligned; bit cfg_len-1 is the first bit received.
- cfg_len  in  LEN_W  pattern length, legal range 1..MAX_W.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = restart after a match.
- match  out  1  Mealy output: high in the cycle the final pattern bit is presented.
- match_cnt  out  CNT_W  saturating count of matches.
- cfg_err  out  1  sticky flag: last cfg_load was illegal.

Behaviour:
- Reset (rst=0, async): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, hist=0, fill=0, match_cnt=0, cfg_err=0. match=0 while reset is held.
- State:
  - hist: MAX_W-bit shift register of received bits.
  - fill: 0..MAX_W count of valid history bits.
  - Together these encode the matched-prefix state; no separate enum.
- Candidate window:
  - cand = {hist[MAX_W-2:0], in}.
  - Compare the low len bits of cand against the low len bits of pattern.
- match (combinational, zero latency) = in_valid & !cfg_load & (fill >= len-1) & (masked cand == masked pattern).
- Accepted bit (in_valid & !cfg_load), next cycle:
  - hist <= cand.
  - If match & !overlap: fill <= 0.
  - Otherwise: fill <= min(fill+1, MAX_W).
- in_valid=0: all state held; match=0.
- match_cnt increments on every match and saturates at all-ones (no wrap).
- cfg_load with 1 <= cfg_len <= MAX_W:
  - Next cycle: new pattern/len/overlap take effect, hist=0, fill=0, cfg_err=0.
  - match_cnt is unchanged.
- cfg_load with cfg_len == 0 or cfg_len > MAX_W:
  - Config, hist and fill are unchanged; cfg_err <= 1.
- cfg_load and in_valid in the same cycle: cfg_load wins, the data bit is dropped, and match is forced to 0.
- len=1: every accepted bit equal to pattern[0] matches, in both modes.
- Reset asserted mid-stream: immediate return to reset values; a partial prefix is discarded.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_REG_EN.
- Defined:
  - match becomes a registered (Moore-style) output, one cycle after the final bit.
  - match_cnt update timing is unchanged; it remains aligned to the comb match.
  - Reset value is 0.
- Undefined: combinational Mealy match as specified above.

Decomposition:
- Package seq_detect_pkg holds:
  - default constants (DEF_PATTERN, DEF_LEN, DEF_OVERLAP);
  - a len_mask(len) function returning a MAX_W-bit mask;
  - a localparam for the CNT saturation value.
- One natural sub-module: seq_detect_cfg.
  - Owns the cfg registers, legality check and cfg_err.
  - Outputs pattern/len/overlap plus a clear pulse to the datapath.

Test Plan:
- Defaults, overlap=0, stream 1,1,0,1,1,0,1,1 (all valid) -> match on bit 5 only; match_cnt=1.
- cfg_load pattern=0x1B, len=5, overlap=1, same stream -> match on bits 5 and 8; match_cnt=2.
- Stream 1,1,0,1,1 with in_valid=0 gaps of 3 cycles between bits -> match on bit 5 only, in its valid cycle; no match in gap cycles.
- cfg_load with cfg_len=0, then stream 1,1,0,1,1 -> cfg_err=1; old config still detects on bit 5. A following legal load clears cfg_err.
- len=1, pattern=1, overlap=0, 300 consecutive 1s -> match every cycle; match_cnt saturates at 255.
- rst pulsed low after bits 1,1,0,1, then bit 1 -> no match; fill=1 after the bit. cfg_load coincident with the last bit -> match=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the seq_detect_param serial pattern detector.
package seq_detect_pkg;

  localparam int unsigned MASK_W      = 32;
  localparam logic [7:0]  DEF_PATTERN = 8'b0001_1011;
  localparam int unsigned DEF_LEN     = 5;
  localparam bit          DEF_OVERLAP = 1'b0;
  localparam logic [31:0] CNT_SAT_ALL = '1;

  function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detect_cfg.sv
// Configuration registers for seq_detect_param: legality check, sticky error
// flag, and a clear pulse to the datapath on every accepted load.
module seq_detect_cfg #(
  parameter int unsigned       MAX_W       = 8,
  parameter int unsigned       LEN_W       = $clog2(MAX_W + 1),
  parameter logic [MAX_W-1:0]  DEF_PATTERN = seq_detect_pkg::DEF_PATTERN,
  parameter int unsigned       DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter bit                DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [MAX_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             overlap_i,
  output logic [MAX_W-1:0] pattern_o,
  output logic [LEN_W-1:0] len_o,
  output logic             overlap_o,
  output logic             clear_o,
  output logic             err_o
);

  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] LEN_RESET = LEN_W'(DEF_LEN);

  logic [MAX_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             overlap_q, overlap_d;
  logic             err_q, err_d;
  logic             legal;

  assign legal   = (len_i != '0) && (len_i <= LEN_MAX);
  assign clear_o = load_i & legal;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    err_d     = err_q;
    if (load_i) begin
      if (legal) begin
        pattern_d = pattern_i;
        len_d     = len_i;
        overlap_d = overlap_i;
        err_d     = 1'b0;
      end else begin
        err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_RESET;
      overlap_q <= DEF_OVERLAP;
      err_q     <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      err_q     <= err_d;
    end
  end

  assign pattern_o = pattern_q;
  assign len_o     = len_q;
  assign overlap_o = overlap_q;
  assign err_o     = err_q;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-programmable Mealy serial pattern detector with saturating match counter.
// Define SEQ_DETECT_MATCH_REG_EN to register the match output (one cycle later).
module seq_detect_param #(
  parameter int unsigned       MAX_W       = 8,
  parameter int unsigned       LEN_W       = $clog2(MAX_W + 1),
  parameter int unsigned       CNT_W       = 8,
  parameter logic [MAX_W-1:0]  DEF_PATTERN = seq_detect_pkg::DEF_PATTERN,
  parameter int unsigned       DEF_LEN     = seq_detect_pkg::DEF_LEN,
  parameter bit                DEF_OVERLAP = seq_detect_pkg::DEF_OVERLAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  import seq_detect_pkg::*;

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_SAT_ALL);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_W);

  logic [MAX_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             clear;

  seq_detect_cfg #(
    .MAX_W       (MAX_W),
    .LEN_W       (LEN_W),
    .DEF_PATTERN (DEF_PATTERN),
    .DEF_LEN     (DEF_LEN),
    .DEF_OVERLAP (DEF_OVERLAP)
  ) u_cfg (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (cfg_load),
    .pattern_i (cfg_pattern),
    .len_i     (cfg_len),
    .overlap_i (cfg_overlap),
    .pattern_o (pattern),
    .len_o     (len),
    .overlap_o (overlap),
    .clear_o   (clear),
    .err_o     (cfg_err)
  );

  // The oldest history bit never reaches the candidate window, so only MAX_W-1 are kept.
  logic [MAX_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAX_W-1:0] cand;
  logic [MAX_W-1:0] mask;
  logic             accept;
  logic             match_c;

  assign accept  = in_valid & ~cfg_load;
  assign cand    = {hist_q, in};
  assign mask    = MAX_W'(len_mask(32'(len)));
  assign match_c = accept
                 & (({1'b0, fill_q} + 1'b1) >= {1'b0, len})
                 & ((cand & mask) == (pattern & mask));

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = cand[MAX_W-2:0];
      if (match_c && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
    if (match_c && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;

`ifdef SEQ_DETECT_MATCH_REG_EN
  logic match_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_c;
    end
  end

  assign match = match_q;
`else
  assign match = match_c;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: driver queues expected match per cycle,
// monitor compares on the falling edge.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       din;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       match;
  logic [7:0] match_cnt;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;

  logic  exp_q[$];
  logic  chk = 1'b0;
  string tag = "idle";

  seq_detect_param dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in          (din),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: one expected match value per driven cycle.
  initial begin
    logic e;
    forever begin
      @(negedge clk);
      if (chk) begin
        if (exp_q.size() == 0) begin
          cmp("sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cmp(tag, int'(match), int'(e));
        end
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic ld, input logic e);
    in_valid = v;
    din      = b;
    cfg_load = ld;
    exp_q.push_back(e);
    chk = 1'b1;
    @(posedge clk);
    #1;
    chk      = 1'b0;
    in_valid = 1'b0;
    cfg_load = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    tag = "load_cycle";
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    din      = 1'b1;
    #2;
    cmp("rst_match", int'(match), 0);
    @(posedge clk);
    #1;
    cmp("rst_cnt", int'(match_cnt), 0);
    cmp("rst_err", int'(cfg_err), 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run5(input string name, input logic [4:0] bits, input logic [4:0] em);
    tag = name;
    for (int i = 4; i >= 0; i--) step(1'b1, bits[i], 1'b0, em[i]);
  endtask

  initial begin
    logic s8[8];
    logic e1[8];
    logic e2[8];
    logic s5[5];
    s8 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    e1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    s5 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b0; in_valid = 1'b0; din = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Defaults, non-overlapping
    do_reset();
    tag = "t1_nonovl";
    for (int i = 0; i < 8; i++) step(1'b1, s8[i], 1'b0, e1[i]);
    cmp("t1_cnt", int'(match_cnt), 1);

    // Overlapping
    do_reset();
    load(8'h1B, 4'd5, 1'b1);
    tag = "t2_ovl";
    for (int i = 0; i < 8; i++) step(1'b1, s8[i], 1'b0, e2[i]);
    cmp("t2_cnt", int'(match_cnt), 2);

    // Valid gaps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tag = "t3_bit";
      step(1'b1, s5[i], 1'b0, (i == 4) ? 1'b1 : 1'b0);
      tag = "t3_gap";
      step(1'b0, ~s5[i], 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cmp("t3_cnt", int'(match_cnt), 1);

    // Illegal loads keep old config
    do_reset();
    load(8'hFF, 4'd0, 1'b1);
    cmp("t4_err_len0", int'(cfg_err), 1);
    load(8'h00, 4'd9, 1'b1);
    cmp("t4_err_len9", int'(cfg_err), 1);
    run5("t4_oldcfg", 5'b11011, 5'b00001);
    cmp("t4_cnt", int'(match_cnt), 1);
    load(8'h1B, 4'd5, 1'b0);
    cmp("t4_err_clr", int'(cfg_err), 0);
    cmp("t4_cnt_kept", int'(match_cnt), 1);

    // len=1 and saturation
    do_reset();
    load(8'h01, 4'd1, 1'b0);
    tag = "t5_len1";
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1);
      if (i == 253) cmp("t5_cnt254", int'(match_cnt), 254);
      if (i == 254) cmp("t5_cnt255", int'(match_cnt), 255);
    end
    cmp("t5_cnt_sat", int'(match_cnt), 255);
    tag = "t5_zero";
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream, then load coincident with final bit
    do_reset();
    tag = "t6_prefix";
    for (int i = 0; i < 4; i++) step(1'b1, s5[i], 1'b0, 1'b0);
    do_reset();
    tag = "t6_after_rst";
    step(1'b1, 1'b1, 1'b0, 1'b0);
    cmp("t6_fill1", int'(dut.fill_q), 1);
    tag = "t6_more";
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    cfg_pattern = 8'h1B; cfg_len = 4'd5; cfg_overlap = 1'b0;
    tag = "t6_load_last";
    step(1'b1, 1'b1, 1'b1, 1'b0);
    cmp("t6_fill_clr", int'(dut.fill_q), 0);
    cmp("t6_cnt", int'(match_cnt), 0);
    run5("t6_fresh", 5'b11011, 5'b00001);
    cmp("t6_cnt_end", int'(match_cnt), 1);

    repeat (3) @(posedge clk);
    cmp("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
